// File: rtl/demux_1x4_stream_pkg.sv
// rtl/demux_1x4_stream_pkg.sv - shared lane constants and types for the 1-to-4 stream demux
package demux_1x4_stream_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [NUM_LANES-1:0] lane_vec_t;
endpackage

// File: rtl/demux_1x4_stream_if.sv
// rtl/demux_1x4_stream_if.sv - producer/consumer stream bundle for the 1-to-4 stream demux
interface demux_1x4_stream_if
  import demux_1x4_stream_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  sel_t                       in_sel;
  logic [WIDTH-1:0]           in_data;
  lane_vec_t                  out_valid;
  lane_vec_t                  out_ready;
  logic [NUM_LANES*WIDTH-1:0] out_data;
  logic [NUM_LANES*CNT_W-1:0] lane_cnt;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, lane_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, lane_cnt
  );
endinterface

// File: rtl/demux_1x4_stream_lane_fifo.sv
// rtl/demux_1x4_stream_lane_fifo.sv - per-lane FIFO; head word is always presented on dout
module demux_lane_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             do_push, do_pop;

  assign full    = (occ_q == FULL_CNT);
  assign empty   = (occ_q == '0);
  // Pushes are judged against the registered occupancy, so a full lane stays full even while draining.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
endmodule

// File: rtl/demux_1x4_stream.sv
// rtl/demux_1x4_stream.sv - registered 1-to-4 stream demux with per-lane FIFOs and accept counters
module demux_1x4_stream
  import demux_1x4_stream_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1x4_stream_if.slave  io
);
  lane_vec_t        full, empty, push, pop;
  logic             in_ready;
  logic [WIDTH-1:0] head [NUM_LANES];
  logic [CNT_W-1:0] cnt_q [NUM_LANES];
  logic [CNT_W-1:0] cnt_d [NUM_LANES];

  // Ready depends only on the selected lane's registered fullness, never on out_ready.
  assign in_ready     = !full[io.in_sel];
  assign io.in_ready  = in_ready;
  assign io.out_valid = ~empty;
  assign pop          = ~empty & io.out_ready;

  always_comb begin
    push = '0;
    if (io.in_valid && in_ready) begin
      push = lane_vec_t'(1) << io.in_sel;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .din   (io.in_data),
      .full  (full[g]),
      .pop   (pop[g]),
      .dout  (head[g]),
      .empty (empty[g])
    );

    assign io.out_data[g*WIDTH +: WIDTH] = head[g];
    assign io.lane_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb/tb_demux_1x4_stream.sv - randomized bench for demux_1x4_stream against a queue-based lane model
module tb_demux_1x4_stream;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [WIDTH-1:0] mdl_q [4][$];
  int unsigned      mdl_cnt [4];

  always #5 clk = ~clk;

  demux_1x4_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux_1x4_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mdl_q[i].delete();
      mdl_cnt[i] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, bus.out_valid[i], mdl_q[i].size() > 0);
      if (mdl_q[i].size() > 0) begin
        check({tag, "_data"}, bus.out_data[i*WIDTH +: WIDTH], mdl_q[i][0]);
      end
      check({tag, "_cnt"}, bus.lane_cnt[i*CNT_W +: CNT_W], mdl_cnt[i] % 256);
    end
  endtask

  // Called near a falling edge: drives inputs, checks ready, predicts the next rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic [3:0] r, input string tag);
    logic acc;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, mdl_q[s].size() < DEPTH);
    acc = v && (mdl_q[s].size() < DEPTH);
    for (int i = 0; i < 4; i++) begin
      if (r[i] && mdl_q[i].size() > 0) void'(mdl_q[i].pop_front());
    end
    if (acc) begin
      mdl_q[s].push_back(d);
      mdl_cnt[s]++;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    model_clear();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 4'b0000);
    check("rst_lane_cnt", bus.lane_cnt, 32'h0);
    check("rst_out_data", bus.out_data, 16'h0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Routing
    step(1'b1, 2'd2, 4'hA, 4'b0000, "route");
    check("route_valid_c", bus.out_valid, 4'b0100);
    check("route_data_c", bus.out_data[2*WIDTH +: WIDTH], 4'hA);
    check("route_cnt_c", bus.lane_cnt, 32'h0001_0000);

    // Backpressure on lane 1
    do_reset();
    step(1'b1, 2'd1, 4'h1, 4'b0000, "bp");
    step(1'b1, 2'd1, 4'h2, 4'b0000, "bp");
    bus.in_sel = 2'd1;
    #1;
    check("bp_full_ready", bus.in_ready, 1'b0);
    step(1'b1, 2'd1, 4'h3, 4'b0010, "bp_drain");
    check("bp_head2", bus.out_data[1*WIDTH +: WIDTH], 4'h2);
    step(1'b0, 2'd1, 4'h0, 4'b0010, "bp_drain");
    check("bp_cnt1", bus.lane_cnt[1*CNT_W +: CNT_W], 8'd2);
    check("bp_empty", bus.out_valid[1], 1'b0);

    // Lane independence
    do_reset();
    step(1'b1, 2'd0, 4'h7, 4'b0000, "ind");
    step(1'b1, 2'd0, 4'h8, 4'b0000, "ind");
    step(1'b1, 2'd3, 4'h5, 4'b0000, "ind");
    check("ind_lane3", bus.out_data[3*WIDTH +: WIDTH], 4'h5);
    check("ind_lane0", bus.out_data[0*WIDTH +: WIDTH], 4'h7);

    // Push and pop together on a one-entry lane
    do_reset();
    step(1'b1, 2'd2, 4'h4, 4'b0000, "pp");
    step(1'b1, 2'd2, 4'h9, 4'b0100, "pp");
    check("pp_head", bus.out_data[2*WIDTH +: WIDTH], 4'h9);
    step(1'b0, 2'd2, 4'h0, 4'b0100, "pp");
    check("pp_empty", bus.out_valid[2], 1'b0);

    // Counter wrap on lane 0
    do_reset();
    for (int n = 0; n < 256; n++) begin
      step(1'b1, 2'd0, WIDTH'($urandom), 4'b0001, "wrap");
    end
    check("wrap_cnt0", bus.lane_cnt[0 +: CNT_W], 8'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom), WIDTH'($urandom),
           4'($urandom), "rand");
    end

    // Asynchronous reset between edges
    for (int n = 0; n < 6; n++) begin
      step(1'b1, 2'($urandom), WIDTH'($urandom), 4'b0000, "pre_async");
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 4'b0000);
    check("async_lane_cnt", bus.lane_cnt, 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_in_ready", bus.in_ready, 1'b1);
    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 9) < 6), 2'($urandom), WIDTH'($urandom),
           4'($urandom), "post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
